// File: rtl/puf_crp_engine.sv
// Challenge-response sequencer for an arbiter PUF: walks a challenge range,
// majority-votes repeated samples and streams packed response words.
module puf_crp_engine #(
    parameter int CH_W   = 8,
    parameter int RESP_W = 16,
    parameter int VOTES  = 5,
    parameter int SETTLE = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [CH_W-1:0]              ch_start,
    input  logic [CH_W:0]                ch_count,
    output logic [CH_W-1:0]              puf_ch,
    output logic                         puf_clr,
    output logic                         puf_launch,
    input  logic                         puf_resp,
    output logic [RESP_W-1:0]            resp_word,
    output logic [$clog2(RESP_W+1)-1:0]  resp_unstable,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic                         busy,
    output logic                         done
);

    localparam int UW    = $clog2(RESP_W + 1);
    localparam int VC_W  = $clog2(VOTES + 1);
    localparam int SC_W  = $clog2(SETTLE + 3);
    localparam int IDX_W = (RESP_W > 1) ? $clog2(RESP_W) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_LAUNCH = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_SAMPLE = 3'd4;
    localparam logic [2:0] S_DECIDE = 3'd5;
    localparam logic [2:0] S_OUTPUT = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;

    logic [2:0]        state_q,     state_d;
    logic [CH_W-1:0]   ch_q,        ch_d;
    logic [CH_W:0]     remain_q,    remain_d;
    logic [VC_W-1:0]   vote_cnt_q,  vote_cnt_d;
    logic [VC_W-1:0]   ones_q,      ones_d;
    logic [SC_W-1:0]   settle_q,    settle_d;
    logic [IDX_W-1:0]  bit_idx_q,   bit_idx_d;
    logic [RESP_W-1:0] word_q,      word_d;
    logic [UW-1:0]     unstable_q,  unstable_d;
    logic              sync1_q,     sync2_q;
    logic              voted_bit;

    assign voted_bit = (ones_q > VC_W'(VOTES / 2));

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        remain_d   = remain_q;
        vote_cnt_d = vote_cnt_q;
        ones_d     = ones_q;
        settle_d   = settle_q;
        bit_idx_d  = bit_idx_q;
        word_d     = word_q;
        unstable_d = unstable_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ch_d       = ch_start;
                    remain_d   = (ch_count == '0) ? (CH_W+1)'(1) : ch_count;
                    vote_cnt_d = '0;
                    ones_d     = '0;
                    bit_idx_d  = '0;
                    word_d     = '0;
                    unstable_d = '0;
                    state_d    = S_CLEAR;
                end
            end
            S_CLEAR:  state_d = S_LAUNCH;
            S_LAUNCH: begin
                settle_d = '0;
                state_d  = S_SETTLE;
            end
            // Extra two cycles cover the synchroniser latency on puf_resp.
            S_SETTLE: begin
                if (settle_q == SC_W'(SETTLE + 1)) begin
                    state_d = S_SAMPLE;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            S_SAMPLE: begin
                ones_d     = ones_q + VC_W'(sync2_q);
                vote_cnt_d = vote_cnt_q + 1'b1;
                state_d    = (vote_cnt_d < VC_W'(VOTES)) ? S_CLEAR : S_DECIDE;
            end
            S_DECIDE: begin
                word_d[bit_idx_q] = voted_bit;
                if (ones_q != '0 && ones_q != VC_W'(VOTES)) begin
                    unstable_d = unstable_q + 1'b1;
                end
                ones_d     = '0;
                vote_cnt_d = '0;
                remain_d   = remain_q - 1'b1;
                ch_d       = ch_q + 1'b1;
                if (bit_idx_q == IDX_W'(RESP_W - 1) || remain_d == '0) begin
                    state_d = S_OUTPUT;
                end else begin
                    bit_idx_d = bit_idx_q + 1'b1;
                    state_d   = S_CLEAR;
                end
            end
            S_OUTPUT: begin
                if (resp_ready) begin
                    word_d     = '0;
                    unstable_d = '0;
                    bit_idx_d  = '0;
                    state_d    = (remain_q == '0) ? S_DONE : S_CLEAR;
                end
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            ch_q       <= '0;
            remain_q   <= '0;
            vote_cnt_q <= '0;
            ones_q     <= '0;
            settle_q   <= '0;
            bit_idx_q  <= '0;
            word_q     <= '0;
            unstable_q <= '0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            remain_q   <= remain_d;
            vote_cnt_q <= vote_cnt_d;
            ones_q     <= ones_d;
            settle_q   <= settle_d;
            bit_idx_q  <= bit_idx_d;
            word_q     <= word_d;
            unstable_q <= unstable_d;
            sync1_q    <= puf_resp;
            sync2_q    <= sync1_q;
        end
    end

    assign puf_ch        = ch_q;
    assign puf_clr       = (state_q == S_CLEAR);
    assign puf_launch    = (state_q == S_LAUNCH);
    assign resp_word     = word_q;
    assign resp_unstable = unstable_q;
    assign resp_valid    = (state_q == S_OUTPUT);
    assign busy          = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done          = (state_q == S_DONE);

endmodule

// File: tb/tb_puf_crp_engine.sv
// Directed bench for puf_crp_engine: a behavioural arbiter model answers each
// launch, and collected words are compared against hand-computed values.
module tb_puf_crp_engine;

    localparam int CH_W   = 8;
    localparam int RESP_W = 16;
    localparam int VOTES  = 5;
    localparam int SETTLE = 4;
    localparam int UW     = $clog2(RESP_W + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [CH_W-1:0]   ch_start = '0;
    logic [CH_W:0]     ch_count = '0;
    logic [CH_W-1:0]   puf_ch;
    logic              puf_clr;
    logic              puf_launch;
    logic              puf_resp;
    logic [RESP_W-1:0] resp_word;
    logic [UW-1:0]     resp_unstable;
    logic              resp_valid;
    logic              resp_ready = 1'b0;
    logic              busy;
    logic              done;

    int checkCount = 0;
    int passCount  = 0;
    int pufMode    = 0;
    int voteIdx    = VOTES - 1;
    int launchCount = 0;
    int chSeqN     = 0;
    logic [CH_W-1:0] chSeq [0:7];

    puf_crp_engine #(.CH_W(CH_W), .RESP_W(RESP_W), .VOTES(VOTES), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst(rst), .start(start), .ch_start(ch_start), .ch_count(ch_count),
        .puf_ch(puf_ch), .puf_clr(puf_clr), .puf_launch(puf_launch), .puf_resp(puf_resp),
        .resp_word(resp_word), .resp_unstable(resp_unstable), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Arbiter model: mode 0 parity, mode 1 parity with a flaky challenge 3, mode 2 challenge LSB.
    function automatic logic pufModel(input logic [CH_W-1:0] ch, input int v, input int mode);
        if (mode == 1 && ch == 8'd3) return (v < 2);
        if (mode == 2) return ch[0];
        return ^ch;
    endfunction

    assign puf_resp = pufModel(puf_ch, voteIdx, pufMode);

    // Tracks which vote of the current challenge is being launched.
    always @(negedge clk) begin
        if (!rst) begin
            voteIdx = VOTES - 1;
        end else if (puf_launch) begin
            voteIdx = (voteIdx == VOTES - 1) ? 0 : voteIdx + 1;
            launchCount++;
            if (voteIdx == 0 && chSeqN < 8) begin
                chSeq[chSeqN] = puf_ch;
                chSeqN++;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic [CH_W-1:0] chs, input logic [CH_W:0] chc, input int mode);
        pufMode     = mode;
        launchCount = 0;
        chSeqN      = 0;
        ch_start    = chs;
        ch_count    = chc;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
    endtask

    task automatic waitValid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (resp_valid) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic waitDone(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (done) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic handshake();
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic collectWord(input string tag, input logic [RESP_W-1:0] expWord, input int expUnst);
        bit ok;
        waitValid(ok);
        checkOutput({tag, "_valid_seen"}, 32'(ok), 32'd1);
        checkOutput({tag, "_word"}, 32'(resp_word), 32'(expWord));
        checkOutput({tag, "_unstable"}, 32'(resp_unstable), 32'(expUnst));
        handshake();
    endtask

    initial begin
        bit ok;
        int holdErr;
        logic [RESP_W-1:0] heldWord;

        repeat (3) @(negedge clk);
        checkOutput("reset_valid", 32'(resp_valid), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_word", 32'(resp_word), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Parity over 0..15 in one word.
        applyStimulus(8'd0, 9'd16, 0);
        checkOutput("t1_busy", 32'(busy), 32'd1);
        collectWord("t1", 16'h6996, 0);
        waitDone(ok);
        checkOutput("t1_done", 32'(ok), 32'd1);
        checkOutput("t1_launches", 32'(launchCount), 32'd80);
        @(negedge clk);
        checkOutput("t1_busy_after", 32'(busy), 32'd0);

        // Challenge 3 votes 1,1,0,0,0: majority 0 but unstable.
        applyStimulus(8'd0, 9'd16, 1);
        collectWord("t2", 16'h6996, 1);
        waitDone(ok);
        @(negedge clk);

        // Two words with backpressure on the first.
        applyStimulus(8'd0, 9'd20, 0);
        waitValid(ok);
        checkOutput("t3_valid_seen", 32'(ok), 32'd1);
        heldWord = resp_word;
        holdErr = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!resp_valid || resp_word !== heldWord) holdErr++;
        end
        checkOutput("t3_hold_stable", 32'(holdErr), 32'd0);
        checkOutput("t3_word0", 32'(resp_word), 32'h6996);
        handshake();
        waitValid(ok);
        checkOutput("t3_done_not_early", 32'(done), 32'd0);
        checkOutput("t3_word1", 32'(resp_word), 32'h0009);
        checkOutput("t3_unstable1", 32'(resp_unstable), 32'd0);
        handshake();
        waitDone(ok);
        checkOutput("t3_done", 32'(ok), 32'd1);
        @(negedge clk);

        // Challenge counter wraps FE, FF, 00, 01.
        applyStimulus(8'hFE, 9'd4, 2);
        collectWord("t4", 16'h000A, 0);
        waitDone(ok);
        checkOutput("t4_nchal", 32'(chSeqN), 32'd4);
        checkOutput("t4_ch0", 32'(chSeq[0]), 32'hFE);
        checkOutput("t4_ch1", 32'(chSeq[1]), 32'hFF);
        checkOutput("t4_ch2", 32'(chSeq[2]), 32'h00);
        checkOutput("t4_ch3", 32'(chSeq[3]), 32'h01);
        @(negedge clk);

        // Reset during SETTLE of challenge 5, then a clean rerun.
        applyStimulus(8'd0, 9'd16, 0);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (puf_launch && puf_ch == 8'd5) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput("t5_reached_ch5", 32'(ok), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t5_rst_ch", 32'(puf_ch), 32'd0);
        checkOutput("t5_rst_ctrl", {27'd0, puf_clr, puf_launch, resp_valid, busy, done}, 32'd0);
        checkOutput("t5_rst_word", 32'(resp_word), 32'd0);
        checkOutput("t5_rst_unst", 32'(resp_unstable), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        applyStimulus(8'd0, 9'd16, 0);
        collectWord("t5", 16'h6996, 0);
        waitDone(ok);
        checkOutput("t5_done", 32'(ok), 32'd1);
        @(negedge clk);

        // Count 0 means one challenge; start while busy is ignored.
        applyStimulus(8'd7, 9'd0, 0);
        repeat (3) @(negedge clk);
        ch_start = 8'h30;
        ch_count = 9'd5;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        collectWord("t6", 16'h0001, 0);
        waitDone(ok);
        checkOutput("t6_done", 32'(ok), 32'd1);
        repeat (20) @(negedge clk);
        checkOutput("t6_launches", 32'(launchCount), 32'd5);
        checkOutput("t6_first_ch", 32'(chSeq[0]), 32'h07);
        checkOutput("t6_busy_idle", 32'(busy), 32'd0);
        checkOutput("t6_no_valid", 32'(resp_valid), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
